// File: rtl/axis_rx_checker.sv
`timescale 1ns/1ps
// axis_rx_checker
// ----------------
// AXI-Stream sink that sits directly on the panic RX output. It accepts the
// packets panic forwards toward DMA and checks three things: framing (runt
// packets), tkeep legality, and the payload sequence. It also keeps
// statistics counters and a fixed-window throughput figure for the logging flow.
//
// Packet format: beat 0 is the UDP header. Payload beat k (k >= 1) carries
// base+k in bits [63:0]. Each new packet uses a base one higher than the
// previous packet's base.
//
// Ports
//   clk, rst          clock; synchronous active-high reset
//   enable            accept traffic; s_axis_tready follows it one cycle later
//   clear             synchronous statistics clear (FSM keeps running)
//   s_axis_*          AXI-Stream slave (tdata/tkeep/tvalid/tready/tlast)
//   pkt_count         packets completed (saturating)
//   byte_count        accepted bytes, popcount of tkeep (saturating, 48 bit)
//   keep_err_count    beats with an illegal tkeep
//   seq_err_count     payload / inter-packet base mismatches
//   runt_err_count    single-beat packets
//   flow_id           tdata[287:280] of the most recent header beat
//   last_pkt_beats    beat count of the most recently completed packet
//   interval_bytes    bytes accepted in the last closed window
//   interval_valid    one-cycle pulse when interval_bytes updates
//   dbg_state         current FSM state (0=HDR, 1=FIRST, 2=BODY)
//
// Handshake: a beat transfers on a rising clk edge where s_axis_tvalid and
// s_axis_tready are both high. s_axis_tready is a flop that loads enable on
// every edge, so it depends on no input combinationally. A beat offered while
// tready is low simply waits, and the FSM holds its state.
module axis_rx_checker #(
  parameter int DATA_WIDTH = 512,
  parameter int KEEP_WIDTH = DATA_WIDTH / 8,
  parameter int INTERVAL   = 4096,
  parameter int CNT_WIDTH  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  enable,
  input  logic                  clear,
  input  logic [DATA_WIDTH-1:0] s_axis_tdata,
  input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
  input  logic                  s_axis_tvalid,
  output logic                  s_axis_tready,
  input  logic                  s_axis_tlast,
  output logic [CNT_WIDTH-1:0]  pkt_count,
  output logic [47:0]           byte_count,
  output logic [CNT_WIDTH-1:0]  keep_err_count,
  output logic [CNT_WIDTH-1:0]  seq_err_count,
  output logic [CNT_WIDTH-1:0]  runt_err_count,
  output logic [7:0]            flow_id,
  output logic [15:0]           last_pkt_beats,
  output logic [31:0]           interval_bytes,
  output logic                  interval_valid,
  output logic [1:0]            dbg_state
);

  localparam int CYC_W = $clog2(INTERVAL);
  localparam int POP_W = $clog2(KEEP_WIDTH + 1);
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(INTERVAL - 1);

  typedef enum logic [1:0] {
    ST_HDR   = 2'd0,
    ST_FIRST = 2'd1,
    ST_BODY  = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic                 tready_q, tready_d;
  logic [15:0]          beat_idx_q, beat_idx_d;
  logic [63:0]          cur_base_q, cur_base_d;
  logic [63:0]          prev_base_q, prev_base_d;
  logic                 base_valid_q, base_valid_d;
  logic [7:0]           flow_id_q, flow_id_d;
  logic [15:0]          last_pkt_beats_q, last_pkt_beats_d;
  logic [CNT_WIDTH-1:0] pkt_count_q, pkt_count_d;
  logic [47:0]          byte_count_q, byte_count_d;
  logic [CNT_WIDTH-1:0] keep_err_q, keep_err_d;
  logic [CNT_WIDTH-1:0] seq_err_q, seq_err_d;
  logic [CNT_WIDTH-1:0] runt_err_q, runt_err_d;
  logic [31:0]          acc_q, acc_d;
  logic [CYC_W-1:0]     cyc_q, cyc_d;
  logic [31:0]          interval_bytes_q, interval_bytes_d;
  logic                 interval_valid_q, interval_valid_d;

  logic                  accept;
  logic                  count_en;
  logic [63:0]           payload;
  logic [63:0]           first_base;
  logic [15:0]           beat_idx_inc;
  logic [POP_W-1:0]      beat_bytes;
  logic [KEEP_WIDTH:0]   keep_plus_one;
  logic                  keep_contig;
  logic                  keep_bad;
  logic                  seq_bad;
  logic [48:0]           byte_sum;
  logic [32:0]           acc_sum;
  logic                  unused_tdata;

  // Only the 64-bit sequence field and the flow byte matter; the rest of
  // the payload is folded here to mark it as intentionally ignored.
  assign unused_tdata = ^s_axis_tdata;

  assign accept   = s_axis_tvalid & tready_q;
  // A beat taken during clear still moves the FSM but adds to no statistic.
  assign count_en = accept & ~clear;

  assign payload      = s_axis_tdata[63:0];
  assign first_base   = payload - 64'd1;
  assign beat_idx_inc = (&beat_idx_q) ? beat_idx_q : beat_idx_q + 16'd1;

  always_comb begin
    beat_bytes = '0;
    for (int i = 0; i < KEEP_WIDTH; i++) begin
      beat_bytes = beat_bytes + POP_W'(s_axis_tkeep[i]);
    end
  end

  // A last-beat tkeep of the form 2^n-1 has no bit in common with itself+1.
  assign keep_plus_one = {1'b0, s_axis_tkeep} + (KEEP_WIDTH+1)'(1);
  assign keep_contig   = (|s_axis_tkeep) &&
                         (({1'b0, s_axis_tkeep} & keep_plus_one) == '0);
  assign keep_bad      = s_axis_tlast ? ~keep_contig : ~(&s_axis_tkeep);

  assign byte_sum = {1'b0, byte_count_q} + 49'(beat_bytes);
  assign acc_sum  = {1'b0, acc_q} + 33'(beat_bytes);

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  always_comb begin
    state_d          = state_q;
    tready_d         = enable;
    beat_idx_d       = beat_idx_q;
    cur_base_d       = cur_base_q;
    prev_base_d      = prev_base_q;
    base_valid_d     = base_valid_q;
    flow_id_d        = flow_id_q;
    last_pkt_beats_d = last_pkt_beats_q;
    pkt_count_d      = pkt_count_q;
    byte_count_d     = byte_count_q;
    keep_err_d       = keep_err_q;
    seq_err_d        = seq_err_q;
    runt_err_d       = runt_err_q;
    acc_d            = acc_q;
    cyc_d            = cyc_q;
    interval_bytes_d = interval_bytes_q;
    interval_valid_d = 1'b0;
    seq_bad          = 1'b0;

    if (accept) begin
      beat_idx_d = beat_idx_inc;
      unique case (state_q)
        ST_HDR: begin
          flow_id_d = s_axis_tdata[35*8 +: 8];
          if (!s_axis_tlast) state_d = ST_FIRST;
        end
        ST_FIRST: begin
          // The first payload beat defines this packet's base; it must follow
          // the previous packet's base unless no base has been seen yet.
          seq_bad      = base_valid_q && (first_base != prev_base_q + 64'd1);
          cur_base_d   = first_base;
          prev_base_d  = first_base;
          base_valid_d = 1'b1;
          state_d      = s_axis_tlast ? ST_HDR : ST_BODY;
        end
        ST_BODY: begin
          seq_bad = (payload != cur_base_q + {48'd0, beat_idx_q});
          if (s_axis_tlast) state_d = ST_HDR;
        end
        default: state_d = ST_HDR;
      endcase

      if (s_axis_tlast) begin
        last_pkt_beats_d = beat_idx_inc;
        beat_idx_d       = '0;
      end

      if (count_en) begin
        byte_count_d = byte_sum[48] ? '1 : byte_sum[47:0];
        acc_d        = acc_sum[32] ? '1 : acc_sum[31:0];
        if (keep_bad) keep_err_d = sat_inc(keep_err_q);
        if (seq_bad)  seq_err_d  = sat_inc(seq_err_q);
        if (s_axis_tlast) begin
          pkt_count_d = sat_inc(pkt_count_q);
          if (state_q == ST_HDR) runt_err_d = sat_inc(runt_err_q);
        end
      end
    end

    // The window closes on its last cycle and includes that cycle's beat.
    if (cyc_q == CYC_LAST) begin
      interval_bytes_d = acc_d;
      interval_valid_d = 1'b1;
      acc_d            = '0;
      cyc_d            = '0;
    end else begin
      cyc_d = cyc_q + CYC_W'(1);
    end

    if (clear) begin
      pkt_count_d  = '0;
      byte_count_d = '0;
      keep_err_d   = '0;
      seq_err_d    = '0;
      runt_err_d   = '0;
      acc_d        = '0;
      cyc_d        = '0;
      base_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q          <= ST_HDR;
      tready_q         <= 1'b0;
      beat_idx_q       <= '0;
      cur_base_q       <= '0;
      prev_base_q      <= '0;
      base_valid_q     <= 1'b0;
      flow_id_q        <= '0;
      last_pkt_beats_q <= '0;
      pkt_count_q      <= '0;
      byte_count_q     <= '0;
      keep_err_q       <= '0;
      seq_err_q        <= '0;
      runt_err_q       <= '0;
      acc_q            <= '0;
      cyc_q            <= '0;
      interval_bytes_q <= '0;
      interval_valid_q <= 1'b0;
    end else begin
      state_q          <= state_d;
      tready_q         <= tready_d;
      beat_idx_q       <= beat_idx_d;
      cur_base_q       <= cur_base_d;
      prev_base_q      <= prev_base_d;
      base_valid_q     <= base_valid_d;
      flow_id_q        <= flow_id_d;
      last_pkt_beats_q <= last_pkt_beats_d;
      pkt_count_q      <= pkt_count_d;
      byte_count_q     <= byte_count_d;
      keep_err_q       <= keep_err_d;
      seq_err_q        <= seq_err_d;
      runt_err_q       <= runt_err_d;
      acc_q            <= acc_d;
      cyc_q            <= cyc_d;
      interval_bytes_q <= interval_bytes_d;
      interval_valid_q <= interval_valid_d;
    end
  end

  assign s_axis_tready  = tready_q;
  assign pkt_count      = pkt_count_q;
  assign byte_count     = byte_count_q;
  assign keep_err_count = keep_err_q;
  assign seq_err_count  = seq_err_q;
  assign runt_err_count = runt_err_q;
  assign flow_id        = flow_id_q;
  assign last_pkt_beats = last_pkt_beats_q;
  assign interval_bytes = interval_bytes_q;
  assign interval_valid = interval_valid_q;
  assign dbg_state      = state_q;

endmodule

// File: tb/tb_axis_rx_checker.sv
`timescale 1ns/1ps
// Testbench for axis_rx_checker: reset values, hand-computed packet table,
// enable/clear/reset corner sequences, throughput windows, and randomized
// packets against a packet-level reference model.
module tb_axis_rx_checker;
  localparam int DW         = 512;
  localparam int KW         = 64;
  localparam int INTERVAL   = 4096;
  localparam int CW         = 32;
  localparam int CLR_EDGE   = 2 * INTERVAL + 1000;
  localparam int WIN_EDGES  = CLR_EDGE + INTERVAL + 12;
  localparam logic [63:0] FULL = {64{1'b1}};

  // ---------------- clock / reset / DUT ----------------
  logic          clk = 1'b0;
  logic          rst, enable, clear;
  logic [DW-1:0] s_axis_tdata;
  logic [KW-1:0] s_axis_tkeep;
  logic          s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [CW-1:0] pkt_count, keep_err_count, seq_err_count, runt_err_count;
  logic [47:0]   byte_count;
  logic [7:0]    flow_id;
  logic [15:0]   last_pkt_beats;
  logic [31:0]   interval_bytes;
  logic          interval_valid;
  logic [1:0]    dbg_state;

  always #2 clk = ~clk;

  axis_rx_checker #(.DATA_WIDTH(DW), .KEEP_WIDTH(KW), .INTERVAL(INTERVAL), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .enable(enable), .clear(clear),
    .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
    .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tlast(s_axis_tlast),
    .pkt_count(pkt_count), .byte_count(byte_count), .keep_err_count(keep_err_count),
    .seq_err_count(seq_err_count), .runt_err_count(runt_err_count), .flow_id(flow_id),
    .last_pkt_beats(last_pkt_beats), .interval_bytes(interval_bytes),
    .interval_valid(interval_valid), .dbg_state(dbg_state)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int failures = 0;
  logic [63:0] exp_q[$];   // expected last_pkt_beats, one per completed packet

  longint unsigned m_pkt, m_bytes, m_keep, m_seq, m_runt;
  logic [7:0]      m_flow;
  logic [63:0]     m_prev;
  bit              m_have;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    m_pkt = 0; m_bytes = 0; m_keep = 0; m_seq = 0; m_runt = 0;
    m_flow = 8'd0; m_prev = 64'd0; m_have = 1'b0;
    exp_q.delete();
  endtask

  // Legal tkeep: all ones on a non-last beat, 2^n-1 with n in 1..64 on the last.
  function automatic bit keep_legal(input logic [63:0] k, input bit last);
    logic [63:0] m;
    if (!last) return (k == FULL);
    m = 64'd0;
    for (int n = 1; n <= 64; n++) begin
      m = {m[62:0], 1'b1};
      if (k == m) return 1'b1;
    end
    return 1'b0;
  endfunction

  task automatic check_model(input string tag);
    chk({tag, ".pkt_count"}, pkt_count, m_pkt);
    chk({tag, ".byte_count"}, byte_count, m_bytes);
    chk({tag, ".keep_err"}, keep_err_count, m_keep);
    chk({tag, ".seq_err"}, seq_err_count, m_seq);
    chk({tag, ".runt_err"}, runt_err_count, m_runt);
    chk({tag, ".flow_id"}, flow_id, m_flow);
    chk({tag, ".state_hdr"}, dbg_state, 2'd0);
    if (exp_q.size() > 0) chk({tag, ".last_pkt_beats"}, last_pkt_beats, exp_q.pop_front());
  endtask

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0; clear = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  // Offer one beat and return just after the edge that accepts it.
  task automatic send_beat(input logic [DW-1:0] d, input logic [63:0] k, input bit last, input bit clr);
    int waited;
    @(negedge clk);
    s_axis_tdata = d; s_axis_tkeep = k; s_axis_tlast = last; s_axis_tvalid = 1'b1; clear = clr;
    waited = 0;
    while (s_axis_tready !== 1'b1 && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (waited >= 200) begin
      checks++; failures++;
      $display("FAIL handshake_timeout: tready low for %0d cycles, expected high", waited);
    end
    @(posedge clk);
    #1 clear = 1'b0;
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < DW / 32; i++) d[i*32 +: 32] = $urandom;
    return d;
  endfunction

  // Send a whole packet and fold its effect into the reference model.
  task automatic send_pkt(input logic [7:0] flow, input int n, input logic [63:0] base,
                          input int bad_k, input logic [63:0] bad_val,
                          input logic [63:0] keep_hdr, input logic [63:0] keep_last, input bit clr_hdr);
    logic [DW-1:0] d;
    logic [63:0]   k, pb;
    logic [63:0]   pay[$];
    bit            last;
    if (clr_hdr) begin
      m_pkt = 0; m_bytes = 0; m_keep = 0; m_seq = 0; m_runt = 0; m_have = 1'b0;
    end
    for (int i = 0; i < n; i++) begin
      d = rand_data();
      last = (i == n - 1);
      if (i == 0) d[287:280] = flow;
      else d[63:0] = (i == bad_k) ? bad_val : base + 64'(i);
      k = last ? keep_last : ((i == 0) ? keep_hdr : FULL);
      send_beat(d, k, last, (i == 0) && clr_hdr);
      if (i > 0) pay.push_back(d[63:0]);
      if (!((i == 0) && clr_hdr)) begin
        m_bytes += $countones(k);
        if (!keep_legal(k, last)) m_keep++;
      end
    end
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    m_flow = flow;
    if (n == 1) m_runt++;
    else begin
      pb = pay[0] - 64'd1;
      if (m_have && pb != m_prev + 64'd1) m_seq++;
      m_prev = pb; m_have = 1'b1;
      for (int j = 1; j < pay.size(); j++) if (pay[j] != pb + 64'(j + 1)) m_seq++;
    end
    m_pkt++;
    exp_q.push_back(64'(n));
  endtask

  // ---------------- table-driven vectors ----------------
  typedef struct {
    logic [7:0]  flow;
    int          n;
    logic [63:0] base;
    int          bad_k;
    logic [63:0] bad_val;
    logic [63:0] keep_hdr;
    logic [63:0] keep_last;
    int          e_pkt;
    longint      e_bytes;
    int          e_keep;
    int          e_seq;
    int          e_runt;
    int          e_last;
  } vec_t;

  vec_t vecs[8];

  // ---------------- throughput windows ----------------
  task automatic window_test();
    int              win_cyc, pulses, pos;
    longint unsigned win_bytes, exp_bytes, tot_bytes, tot_pkts;
    bit              tr_exp, acc, clr, exp_v;
    logic [63:0]     base;
    logic [DW-1:0]   d;
    win_cyc = 0; win_bytes = 0; exp_bytes = 0; tot_bytes = 0; tot_pkts = 0;
    pulses = 0; pos = 0; base = 64'd1000; tr_exp = 1'b0;
    for (int e = 1; e <= WIN_EDGES; e++) begin
      enable = ($urandom_range(0, 9) != 0);
      s_axis_tvalid = ($urandom_range(0, 4) != 0);
      clr = (e == CLR_EDGE);
      clear = clr;
      d = rand_data();
      if (pos != 0) d[63:0] = base + 64'(pos);
      s_axis_tdata = d; s_axis_tkeep = FULL; s_axis_tlast = (pos == 3);
      @(posedge clk);
      acc = s_axis_tvalid && tr_exp;
      tr_exp = enable;
      exp_v = 1'b0;
      if (acc) begin
        if (!clr) begin
          win_bytes += 64; tot_bytes += 64;
          if (pos == 3) tot_pkts++;
        end
        if (pos == 3) begin pos = 0; base++; end
        else pos++;
      end
      if (clr) begin
        win_cyc = 0; win_bytes = 0; tot_bytes = 0; tot_pkts = 0;
      end else if (win_cyc == INTERVAL - 1) begin
        exp_v = 1'b1; exp_bytes = win_bytes; win_cyc = 0; win_bytes = 0;
      end else begin
        win_cyc++;
      end
      @(negedge clk);
      chk("win.tready", s_axis_tready, tr_exp);
      chk("win.interval_valid", interval_valid, exp_v);
      if (exp_v) begin
        pulses++;
        chk("win.interval_bytes", interval_bytes, exp_bytes);
      end
    end
    clear = 1'b0; s_axis_tvalid = 1'b0; enable = 1'b1;
    chk("win.pulse_count", pulses, 3);
    chk("win.byte_count", byte_count, tot_bytes);
    chk("win.pkt_count", pkt_count, tot_pkts);
    chk("win.seq_err", seq_err_count, 0);
    chk("win.keep_err", keep_err_count, 0);
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    logic [DW-1:0] d;
    logic [63:0]   k, kl, base;
    int            n, bad_k, nb, sel;

    rst = 1'b1; enable = 1'b0; clear = 1'b0;
    s_axis_tdata = '0; s_axis_tkeep = '0; s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;

    vecs[0] = '{8'h11, 4, 64'd1,  -1, 64'd0, FULL, FULL,      1,  256, 0, 0, 0, 4};
    vecs[1] = '{8'h12, 4, 64'd2,  -1, 64'd0, FULL, FULL,      2,  512, 0, 0, 0, 4};
    vecs[2] = '{8'h13, 4, 64'd3,  -1, 64'd0, FULL, FULL,      3,  768, 0, 0, 0, 4};
    vecs[3] = '{8'h14, 4, 64'd4,   2, 64'd9, FULL, FULL,      4, 1024, 0, 1, 0, 4};
    vecs[4] = '{8'h15, 2, 64'd5,  -1, 64'd0, 64'h00FF_FFFF_FFFF_FFFF, 64'h0F0, 5, 1084, 2, 1, 0, 2};
    vecs[5] = '{8'h03, 1, 64'd0,  -1, 64'd0, FULL, FULL,      6, 1148, 2, 1, 1, 1};
    vecs[6] = '{8'h16, 3, 64'd9,  -1, 64'd0, FULL, FULL,      7, 1340, 2, 2, 1, 3};
    vecs[7] = '{8'h17, 5, 64'd10,  4, 64'd0, FULL, 64'd0,     8, 1596, 3, 3, 1, 5};

    // Reset state
    do_reset();
    chk("rst.tready", s_axis_tready, 0);
    chk("rst.pkt_count", pkt_count, 0);
    chk("rst.byte_count", byte_count, 0);
    chk("rst.keep_err", keep_err_count, 0);
    chk("rst.seq_err", seq_err_count, 0);
    chk("rst.runt_err", runt_err_count, 0);
    chk("rst.flow_id", flow_id, 0);
    chk("rst.last_pkt_beats", last_pkt_beats, 0);
    chk("rst.interval_bytes", interval_bytes, 0);
    chk("rst.interval_valid", interval_valid, 0);
    chk("rst.state", dbg_state, 0);

    // tready is enable delayed by one cycle
    enable = 1'b1;
    chk("en.tready_not_yet", s_axis_tready, 0);
    @(negedge clk);
    chk("en.tready_rise", s_axis_tready, 1);

    // Table of hand-computed cumulative results
    for (int v = 0; v < 8; v++) begin
      send_pkt(vecs[v].flow, vecs[v].n, vecs[v].base, vecs[v].bad_k, vecs[v].bad_val,
               vecs[v].keep_hdr, vecs[v].keep_last, 1'b0);
      chk($sformatf("vec%0d.pkt_count", v), pkt_count, 64'(vecs[v].e_pkt));
      chk($sformatf("vec%0d.byte_count", v), byte_count, 64'(vecs[v].e_bytes));
      chk($sformatf("vec%0d.keep_err", v), keep_err_count, 64'(vecs[v].e_keep));
      chk($sformatf("vec%0d.seq_err", v), seq_err_count, 64'(vecs[v].e_seq));
      chk($sformatf("vec%0d.runt_err", v), runt_err_count, 64'(vecs[v].e_runt));
      chk($sformatf("vec%0d.last_pkt_beats", v), last_pkt_beats, 64'(vecs[v].e_last));
      chk($sformatf("vec%0d.flow_id", v), flow_id, vecs[v].flow);
      chk($sformatf("vec%0d.state_hdr", v), dbg_state, 0);
    end

    // enable dropped mid-packet: one more beat slips through, then the FSM holds
    do_reset();
    @(negedge clk);
    d = rand_data(); d[287:280] = 8'h21;
    send_beat(d, FULL, 1'b0, 1'b0);
    d = rand_data(); d[63:0] = 64'd21;
    send_beat(d, FULL, 1'b0, 1'b0);
    @(negedge clk);
    d = rand_data(); d[63:0] = 64'd22;
    s_axis_tdata = d; s_axis_tlast = 1'b0; s_axis_tvalid = 1'b1; enable = 1'b0;
    chk("hold.tready_still_high", s_axis_tready, 1);
    @(negedge clk);
    chk("hold.tready_low", s_axis_tready, 0);
    chk("hold.state_body", dbg_state, 2);
    d = rand_data(); d[63:0] = 64'd23;
    s_axis_tdata = d; s_axis_tlast = 1'b1;
    repeat (4) @(negedge clk);
    chk("hold.state_still_body", dbg_state, 2);
    chk("hold.pkt_count", pkt_count, 0);
    enable = 1'b1;
    @(negedge clk);
    chk("hold.tready_back", s_axis_tready, 1);
    @(posedge clk);
    @(negedge clk);
    s_axis_tvalid = 1'b0; s_axis_tlast = 1'b0;
    chk("hold.pkt_done", pkt_count, 1);
    chk("hold.last_pkt_beats", last_pkt_beats, 4);
    chk("hold.seq_err", seq_err_count, 0);
    chk("hold.byte_count", byte_count, 256);
    chk("hold.state_hdr", dbg_state, 0);

    // clear coincident with a header beat: beat uncounted, FSM advances, base forgotten
    send_pkt(8'h44, 4, 64'd100, -1, 64'd0, FULL, FULL, 1'b1);
    chk("clr.pkt_count", pkt_count, 1);
    chk("clr.byte_count", byte_count, 192);
    chk("clr.seq_err", seq_err_count, 0);
    chk("clr.last_pkt_beats", last_pkt_beats, 4);
    chk("clr.flow_id", flow_id, 8'h44);

    // reset after two beats of a four-beat packet
    d = rand_data(); d[287:280] = 8'h55;
    send_beat(d, FULL, 1'b0, 1'b0);
    d = rand_data(); d[63:0] = 64'd201;
    send_beat(d, FULL, 1'b0, 1'b0);
    do_reset();
    chk("mid_rst.pkt_count", pkt_count, 0);
    chk("mid_rst.byte_count", byte_count, 0);
    chk("mid_rst.state", dbg_state, 0);
    chk("mid_rst.last_pkt_beats", last_pkt_beats, 0);
    send_pkt(8'h56, 4, 64'd500, -1, 64'd0, FULL, FULL, 1'b0);
    chk("mid_rst.next_pkt", pkt_count, 1);
    chk("mid_rst.next_seq", seq_err_count, 0);
    chk("mid_rst.next_runt", runt_err_count, 0);
    chk("mid_rst.next_beats", last_pkt_beats, 4);

    // Throughput windows with a mid-window clear
    do_reset();
    window_test();

    // Randomized packets against the reference model
    do_reset();
    enable = 1'b1;
    @(negedge clk);
    for (int p = 0; p < 40; p++) begin
      n = $urandom_range(1, 6);
      sel = $urandom_range(0, 9);
      if (sel == 0) base = 64'hFFFF_FFFF_FFFF_FFFC;
      else if (sel == 1) base = {$urandom, $urandom};
      else base = m_prev + 64'd1;
      bad_k = -1;
      if (n > 1 && $urandom_range(0, 5) == 0) bad_k = $urandom_range(1, n - 1);
      k = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : FULL;
      sel = $urandom_range(0, 5);
      if (sel == 0) kl = {$urandom, $urandom};
      else if (sel == 1) kl = 64'd0;
      else begin
        nb = $urandom_range(1, 64);
        kl = FULL >> (64 - nb);
      end
      send_pkt(8'($urandom), n, base, bad_k, {$urandom, $urandom}, k, kl, 1'b0);
      check_model($sformatf("rnd%0d", p));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
